alu_issue_arbiter: RTL and testbench

//  Shares the single-cycle combinational ALU among NUM_REQ requesters (e.g. int pipe,

---
 rtl/alu_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/alu_issue_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_issue_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue arbiter: ALU control encodings, the
// legality check for a control code, and the arbiter FSM state type.
package alu_pkg;

  localparam int unsigned ALU_ADD = 1;
  localparam int unsigned ALU_SUB = 2;
  localparam int unsigned ALU_AND = 3;
  localparam int unsigned ALU_OR  = 4;
  localparam int unsigned ALU_SRL = 5;
  localparam int unsigned ALU_SLL = 6;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  // Only codes ALU_ADD..ALU_SLL produce a defined ALU output.
  function automatic logic alu_ctrl_legal(input int unsigned ctrl);
    return (ctrl >= ALU_ADD) && (ctrl <= ALU_SLL);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection. Purely combinational.
//   req      : request vector
//   ptr      : index of the last granted requester
//   grant    : one-hot grant (0 when no request)
//   grant_id : encoded index of the granted requester
//   req_any  : at least one request is present
// The search starts at ptr+1 and wraps, so the last winner has lowest priority.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               req_any
);

  int unsigned idx;
  logic        found;

  assign req_any = |req;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[idx[ID_W-1:0]]) begin
        found                 = 1'b1;
        grant[idx[ID_W-1:0]]  = 1'b1;
        grant_id              = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one external combinational ALU among NUM_REQ requesters.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_ctrl/req_a/req_b: packed per-requester ALU control and operands
//   alu_ctrl/alu_data1/alu_data2 : registered operation driven to the ALU
//   alu_result          : ALU output, sampled at the end of EXEC
//   res_valid/res_ready : result handshake
//   res_data/res_id/res_err : result, issuing requester, illegal-ctrl flag
// Sequence per operation: IDLE (accept) -> EXEC (ALU evaluates) -> RESP (hold).
module alu_issue_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CTRL_W  = 4,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl,
  input  logic [NUM_REQ*WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*WIDTH-1:0]  req_b,
  output logic [CTRL_W-1:0]       alu_ctrl,
  output logic [WIDTH-1:0]        alu_data1,
  output logic [WIDTH-1:0]        alu_data2,
  input  logic [WIDTH-1:0]        alu_result,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [WIDTH-1:0]        res_data,
  output logic [ID_W-1:0]         res_id,
  output logic                    res_err
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [CTRL_W-1:0]   op_ctrl_q;
  logic [WIDTH-1:0]    op_a_q, op_b_q;
  logic [ID_W-1:0]     op_id_q;
  logic                res_valid_q, res_err_q;
  logic [WIDTH-1:0]    res_data_q;
  logic [ID_W-1:0]     res_id_q;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic                req_any;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .grant   (grant),
    .grant_id(grant_id),
    .req_any (req_any)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          req_ready = grant;
          state_d   = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      op_ctrl_q   <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_any) begin
            op_ctrl_q <= req_ctrl[grant_id*CTRL_W +: CTRL_W];
            op_a_q    <= req_a[grant_id*WIDTH +: WIDTH];
            op_b_q    <= req_b[grant_id*WIDTH +: WIDTH];
            op_id_q   <= grant_id;
            rr_ptr_q  <= grant_id;
          end
        end
        EXEC: begin
          res_valid_q <= 1'b1;
          res_id_q    <= op_id_q;
          // ALU output is undefined for illegal codes, so it is never forwarded.
          if (alu_ctrl_legal(32'(op_ctrl_q))) begin
            res_data_q <= alu_result;
            res_err_q  <= 1'b0;
          end else begin
            res_data_q <= '0;
            res_err_q  <= 1'b1;
          end
        end
        RESP: begin
          if (res_ready) res_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Op registers only change on accept, so the ALU inputs stay quiet when idle.
  assign alu_ctrl  = op_ctrl_q;
  assign alu_data1 = op_a_q;
  assign alu_data2 = op_b_q;

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
module tb_alu_issue_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_ctrl;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_data1;
  logic [31:0] alu_data2;
  logic [31:0] alu_result;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_id;
  logic        res_err;

  int errors;
  int checks;
  int exp_ptr;

  alu_issue_arbiter #(
    .NUM_REQ(2),
    .WIDTH  (32),
    .CTRL_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ctrl  (req_ctrl),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_ctrl  (alu_ctrl),
    .alu_data1 (alu_data1),
    .alu_data2 (alu_data2),
    .alu_result(alu_result),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_err   (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU; illegal codes return junk the arbiter must not forward.
  always_comb begin
    case (alu_ctrl)
      4'd1:    alu_result = alu_data1 + alu_data2;
      4'd2:    alu_result = alu_data1 - alu_data2;
      4'd3:    alu_result = alu_data1 & alu_data2;
      4'd4:    alu_result = alu_data1 | alu_data2;
      4'd5:    alu_result = alu_data1 >> alu_data2;
      4'd6:    alu_result = alu_data2 << alu_data1;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic set_req(input int i, input logic v, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]       = v;
    req_ctrl[i*4 +: 4] = c;
    req_a[i*32 +: 32]  = a;
    req_b[i*32 +: 32]  = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_ctrl = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready);
    end
    checks++;
    if ({res_valid, res_err, res_id} !== 3'b000 || res_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_res: got v=%b e=%b id=%b d=%h want all 0",
               res_valid, res_err, res_id, res_data);
    end
    checks++;
    if (alu_ctrl !== 4'd0 || alu_data1 !== 32'd0 || alu_data2 !== 32'd0) begin
      errors++;
      $display("FAIL reset_alu: got c=%h a=%h b=%h want 0", alu_ctrl, alu_data1, alu_data2);
    end
    rst = 1'b0;
    exp_ptr = 1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00 || res_valid !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: got rdy=%b v=%b want 00/0", req_ready, res_valid);
    end
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    set_req(0, 1'b1, 4'd1, 32'd5, 32'd7);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL single_grant: got %b want 01", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || req_ready !== 2'b00) begin
      errors++; $display("FAIL single_exec: got v=%b rdy=%b want 0/00", res_valid, req_ready);
    end
    checks++;
    if (alu_ctrl !== 4'd1 || alu_data1 !== 32'd5 || alu_data2 !== 32'd7) begin
      errors++;
      $display("FAIL single_alu: got c=%h a=%h b=%h want 1/5/7", alu_ctrl, alu_data1, alu_data2);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'd12 || res_id !== 1'b0 || res_err !== 1'b0) begin
      errors++;
      $display("FAIL single_result: got v=%b d=%0d id=%b e=%b want 1/12/0/0",
               res_valid, res_data, res_id, res_err);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL single_drop: got v=%b want 0", res_valid);
    end
    exp_ptr = 0;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_res [2];
    int          g;
    logic [1:0]  exp_gnt;
    exp_res[0] = 32'd7;
    exp_res[1] = 32'h30;
    res_ready = 1'b1;
    set_req(0, 1'b1, 4'd2, 32'd10, 32'd3);
    set_req(1, 1'b1, 4'd3, 32'hF0, 32'h3C);
    for (int it = 0; it < 4; it++) begin
      g = (exp_ptr + 1) % 2;
      exp_gnt = (g == 0) ? 2'b01 : 2'b10;
      #1;
      checks++;
      if (req_ready !== exp_gnt) begin
        errors++; $display("FAIL rr_grant[%0d]: got %b want %b", it, req_ready, exp_gnt);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== exp_res[g] || res_id !== g[0]) begin
        errors++;
        $display("FAIL rr_result[%0d]: got v=%b d=%h id=%b want 1/%h/%0d",
                 it, res_valid, res_data, res_id, exp_res[g], g);
      end
      exp_ptr = g;
      if (it == 3) req_valid = '0;
      @(negedge clk);
    end
  endtask

  task automatic test_operand_order();
    logic [3:0]  c [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    c[0] = 4'd6; a[0] = 32'd4;   b[0] = 32'd1;
    c[1] = 4'd5; a[1] = 32'h80;  b[1] = 32'd3;
    res_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_req(i, 1'b1, c[i], a[i], b[i]);
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++;
      if (alu_data1 !== a[i] || alu_data2 !== b[i]) begin
        errors++;
        $display("FAIL order_alu[%0d]: got a=%h b=%h want %h/%h", i, alu_data1, alu_data2,
                 a[i], b[i]);
      end
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== 32'h10 || res_id !== i[0] || res_err !== 1'b0) begin
        errors++;
        $display("FAIL order_result[%0d]: got v=%b d=%h id=%b e=%b want 1/10/%0d/0",
                 i, res_valid, res_data, res_id, res_err, i);
      end
      exp_ptr = i;
      @(negedge clk);
    end
  endtask

  task automatic test_illegal_ctrl();
    logic [3:0]  c [2];
    logic [31:0] exp_d [2];
    logic        exp_e [2];
    c[0] = 4'd9; exp_d[0] = 32'd0;    exp_e[0] = 1'b1;
    c[1] = 4'd4; exp_d[1] = 32'hFF;   exp_e[1] = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) set_req(0, 1'b1, c[i], 32'd1, 32'd1);
      else        set_req(0, 1'b1, c[i], 32'hF0, 32'h0F);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== exp_d[i] || res_err !== exp_e[i]) begin
        errors++;
        $display("FAIL illegal[%0d]: got v=%b d=%h e=%b want 1/%h/%b",
                 i, res_valid, res_data, res_err, exp_d[i], exp_e[i]);
      end
      @(negedge clk);
    end
    exp_ptr = 0;
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    set_req(0, 1'b1, 4'd1, 32'd1, 32'd2);
    @(negedge clk);
    req_valid = '0;
    set_req(1, 1'b1, 4'd1, 32'd100, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== 32'd3 || res_id !== 1'b0 ||
          req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%0d id=%b rdy=%b want 1/3/0/00",
                 i, res_valid, res_data, res_id, req_ready);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || req_ready !== 2'b10) begin
      errors++; $display("FAIL bp_release: got v=%b rdy=%b want 0/10", res_valid, req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'd101 || res_id !== 1'b1) begin
      errors++;
      $display("FAIL bp_next: got v=%b d=%0d id=%b want 1/101/1", res_valid, res_data, res_id);
    end
    @(negedge clk);
    exp_ptr = 1;
  endtask

  task automatic test_reset_mid_op();
    res_ready = 1'b1;
    set_req(1, 1'b1, 4'd2, 32'd9, 32'd4);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL rst_pre_grant: got %b want 10", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    checks++;
    if (res_valid !== 1'b0 || alu_ctrl !== 4'd0 || alu_data1 !== 32'd0) begin
      errors++;
      $display("FAIL rst_exec_clear: got v=%b c=%h a=%h want 0/0/0", res_valid, alu_ctrl,
               alu_data1);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || req_ready !== 2'b00) begin
      errors++; $display("FAIL rst_no_replay: got v=%b rdy=%b want 0/00", res_valid, req_ready);
    end
    set_req(0, 1'b1, 4'd1, 32'd2, 32'd3);
    set_req(1, 1'b1, 4'd1, 32'd4, 32'd4);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL rst_ptr_grant: got %b want 01", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'd5 || res_id !== 1'b0) begin
      errors++;
      $display("FAIL rst_after_op: got v=%b d=%0d id=%b want 1/5/0", res_valid, res_data, res_id);
    end
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_ptr = 1;
    test_reset();
    test_single();
    test_round_robin();
    test_operand_order();
    test_illegal_ctrl();
    test_backpressure();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
